// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared ALU opcodes, forward-select encodings and hazard helper
package riscv_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1000;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam logic [4:0] REG_X0 = 5'd0;

    // x0 is hardwired to zero, so a write to it never produces a forwardable value
    function automatic logic fwd_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != REG_X0) && (rd == rs);
    endfunction

endpackage

// File: rtl/forward_mux.sv
// rtl/forward_mux.sv - per-operand forwarding compare and 3:1 operand select
module forward_mux
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            valid_i,
    input  logic [4:0]      rs_addr_i,
    input  logic [XLEN-1:0] reg_data_i,
    input  logic [4:0]      exmem_rd_i,
    input  logic            exmem_reg_write_i,
    input  logic [XLEN-1:0] exmem_result_i,
    input  logic [4:0]      memwb_rd_i,
    input  logic            memwb_reg_write_i,
    input  logic [XLEN-1:0] memwb_result_i,
    output logic [1:0]      sel_o,
    output logic [XLEN-1:0] data_o
);

    // EX/MEM holds the younger result, so it is tested first
    always_comb begin
        sel_o = FWD_REG;
        if (valid_i && fwd_hit(exmem_reg_write_i, exmem_rd_i, rs_addr_i)) begin
            sel_o = FWD_EXMEM;
        end else if (valid_i && fwd_hit(memwb_reg_write_i, memwb_rd_i, rs_addr_i)) begin
            sel_o = FWD_MEMWB;
        end
    end

    always_comb begin
        data_o = reg_data_i;
        case (sel_o)
            FWD_EXMEM: data_o = exmem_result_i;
            FWD_MEMWB: data_o = memwb_result_i;
            default:   data_o = reg_data_i;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX stage register with operand forwarding and load-use detect
module id_ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            valid_in,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      rd_addr,
    input  logic [3:0]      alu_op_in,
    input  logic            alu_src_in,
    input  logic            reg_write_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            mem_to_reg_in,
    input  logic            branch_in,
    input  logic [4:0]      exmem_rd,
    input  logic [4:0]      memwb_rd,
    input  logic            exmem_reg_write,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] store_data,
    output logic [4:0]      rd_out,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_to_reg,
    output logic            branch,
    output logic            valid_out,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            load_use_stall
);

    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rs1_addr_q, rs1_addr_d;
    logic [4:0]      rs2_addr_q, rs2_addr_d;
    logic [4:0]      rd_q, rd_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic [6:0]      ctrl_q, ctrl_d;

    logic load_bubble;
    logic load_new;

    // flush beats stall; an empty ID slot loads the same bubble as a flush
    assign load_bubble = flush || (!stall && !valid_in);
    assign load_new    = !flush && !stall && valid_in;

    always_comb begin
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_d       = rd_q;
        alu_op_d   = alu_op_q;
        ctrl_d     = ctrl_q;
        if (load_bubble) begin
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            rs1_addr_d = REG_X0;
            rs2_addr_d = REG_X0;
            rd_d       = REG_X0;
            alu_op_d   = ALU_AND;
            ctrl_d     = '0;
        end else if (load_new) begin
            rs1_data_d = rs1_data;
            rs2_data_d = rs2_data;
            imm_d      = imm;
            rs1_addr_d = rs1_addr;
            rs2_addr_d = rs2_addr;
            rd_d       = rd_addr;
            alu_op_d   = alu_op_in;
            ctrl_d     = {valid_in, alu_src_in, reg_write_in, mem_read_in,
                          mem_write_in, mem_to_reg_in, branch_in};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_addr_q <= REG_X0;
            rs2_addr_q <= REG_X0;
            rd_q       <= REG_X0;
            alu_op_q   <= ALU_AND;
            ctrl_q     <= '0;
        end else begin
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_q       <= rd_d;
            alu_op_q   <= alu_op_d;
            ctrl_q     <= ctrl_d;
        end
    end

    logic alu_src_q;
    assign {valid_out, alu_src_q, reg_write, mem_read, mem_write, mem_to_reg, branch} = ctrl_q;
    assign rd_out = rd_q;
    assign alu_op = alu_op_q;

    forward_mux #(.XLEN(XLEN)) u_fwd_a (
        .valid_i           (valid_out),
        .rs_addr_i         (rs1_addr_q),
        .reg_data_i        (rs1_data_q),
        .exmem_rd_i        (exmem_rd),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_result_i    (exmem_result),
        .memwb_rd_i        (memwb_rd),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_result_i    (memwb_result),
        .sel_o             (fwd_a),
        .data_o            (alu_a)
    );

    forward_mux #(.XLEN(XLEN)) u_fwd_b (
        .valid_i           (valid_out),
        .rs_addr_i         (rs2_addr_q),
        .reg_data_i        (rs2_data_q),
        .exmem_rd_i        (exmem_rd),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_result_i    (exmem_result),
        .memwb_rd_i        (memwb_rd),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_result_i    (memwb_result),
        .sel_o             (fwd_b),
        .data_o            (store_data)
    );

    assign alu_b = alu_src_q ? imm_q : store_data;

    // a load in EX cannot forward its data until MEM, so a dependent ID instruction must wait
    assign load_use_stall = valid_out && mem_read && (rd_q != REG_X0) && valid_in &&
                            ((rd_q == rs1_addr) || (rd_q == rs2_addr));

endmodule
